// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file (2 write, NUM_READ read) with per-register busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp #(
    parameter int WORD_SIZE = 16,
    parameter int REG_INDEX = 3,
    parameter int NUM_READ  = 3,
    parameter int ZERO_REG  = 0
) (
    input  logic                          clk,
    input  logic                          reset_enable,
    input  logic [NUM_READ*REG_INDEX-1:0] rd_num,
    output logic [NUM_READ*WORD_SIZE-1:0] rd_val,
    output logic [NUM_READ-1:0]           rd_busy,
    input  logic                          wr0_enable,
    input  logic [REG_INDEX-1:0]          wr0_num,
    input  logic [WORD_SIZE-1:0]          wr0_val,
    input  logic                          wr1_enable,
    input  logic [REG_INDEX-1:0]          wr1_num,
    input  logic [WORD_SIZE-1:0]          wr1_val,
    input  logic                          issue_enable,
    input  logic [REG_INDEX-1:0]          issue_num,
    output logic [REG_INDEX:0]            pending_count
);
    localparam int DEPTH = 2**REG_INDEX;
    localparam int CW    = REG_INDEX + 1;
    logic [WORD_SIZE-1:0] regs_q [DEPTH];
    logic [WORD_SIZE-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]     busy_q, busy_d;
    logic [CW-1:0]        pending_q, pending_d;
    logic                 w0_ok, w1_ok, iss_ok;
    assign w0_ok  = wr0_enable && !(ZERO_REG != 0 && wr0_num == '0);
    assign w1_ok  = wr1_enable && !(ZERO_REG != 0 && wr1_num == '0);
    assign iss_ok = issue_enable && !(ZERO_REG != 0 && issue_num == '0);
    // wr1 applied after wr0 so it wins a collision; issue applied last so a new producer stays busy
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (w0_ok) begin
            regs_d[wr0_num] = wr0_val;
            busy_d[wr0_num] = 1'b0;
        end
        if (w1_ok) begin
            regs_d[wr1_num] = wr1_val;
            busy_d[wr1_num] = 1'b0;
        end
        if (iss_ok)
            busy_d[issue_num] = 1'b1;
        pending_d = '0;
        for (int i = 0; i < DEPTH; i++)
            pending_d = pending_d + CW'(busy_d[i]);
    end
    always_ff @(posedge clk or posedge reset_enable) begin
        if (reset_enable) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end
    assign pending_count = pending_q;
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [REG_INDEX-1:0] idx;
        logic                 zero;
        assign idx  = rd_num[k*REG_INDEX +: REG_INDEX];
        assign zero = ZERO_REG != 0 && idx == '0;
`ifdef REG_FILE_BYPASS_EN
        logic hit0, hit1;
        assign hit0 = wr0_enable && wr0_num == idx;
        assign hit1 = wr1_enable && wr1_num == idx;
        assign rd_val[k*WORD_SIZE +: WORD_SIZE] = zero ? '0 : hit1 ? wr1_val : hit0 ? wr0_val : regs_q[idx];
        assign rd_busy[k] = !zero && ((hit0 || hit1) ? (issue_enable && issue_num == idx) : busy_q[idx]);
`else
        assign rd_val[k*WORD_SIZE +: WORD_SIZE] = zero ? '0 : regs_q[idx];
        assign rd_busy[k] = !zero && busy_q[idx];
`endif
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: checks reg_file_mp (ZERO_REG=0 and ZERO_REG=1 instances) against an array-based model.
// Expected read values follow REG_FILE_BYPASS_EN when it is defined.
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  rd_num = '0;
    logic [47:0] rv0, rv1;
    logic [2:0]  rb0, rb1;
    logic [3:0]  pc0, pc1;
    logic        wr0_enable = 0, wr1_enable = 0, issue_enable = 0;
    logic [2:0]  wr0_num = 0, wr1_num = 0, issue_num = 0;
    logic [15:0] wr0_val = 0, wr1_val = 0;
    int          passed = 0, total = 0;
    logic [15:0] mreg [2][8];
    logic        mbusy [2][8];

    always #5 clk = ~clk;

    reg_file_mp #(.ZERO_REG(0)) u0 (
        .clk(clk), .reset_enable(rst), .rd_num(rd_num), .rd_val(rv0), .rd_busy(rb0),
        .wr0_enable(wr0_enable), .wr0_num(wr0_num), .wr0_val(wr0_val),
        .wr1_enable(wr1_enable), .wr1_num(wr1_num), .wr1_val(wr1_val),
        .issue_enable(issue_enable), .issue_num(issue_num), .pending_count(pc0));
    reg_file_mp #(.ZERO_REG(1)) u1 (
        .clk(clk), .reset_enable(rst), .rd_num(rd_num), .rd_val(rv1), .rd_busy(rb1),
        .wr0_enable(wr0_enable), .wr0_num(wr0_num), .wr0_val(wr0_val),
        .wr1_enable(wr1_enable), .wr1_num(wr1_num), .wr1_val(wr1_val),
        .issue_enable(issue_enable), .issue_num(issue_num), .pending_count(pc1));

    function automatic int mcount(input int z);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(mbusy[z][i]);
        return n;
    endfunction

    function automatic logic [15:0] exp_rd(input int z, input int idx);
        if (z == 1 && idx == 0) return 16'h0;
`ifdef REG_FILE_BYPASS_EN
        if (wr1_enable && int'(wr1_num) == idx) return wr1_val;
        if (wr0_enable && int'(wr0_num) == idx) return wr0_val;
`endif
        return mreg[z][idx];
    endfunction

    function automatic logic exp_busy(input int z, input int idx);
        if (z == 1 && idx == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
        if ((wr1_enable && int'(wr1_num) == idx) || (wr0_enable && int'(wr0_num) == idx))
            return issue_enable && int'(issue_num) == idx;
`endif
        return mbusy[z][idx];
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < 8; i++) begin
                mreg[z][i]  = '0;
                mbusy[z][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            if (wr0_enable && !(z == 1 && wr0_num == 0)) begin
                mreg[z][wr0_num]  = wr0_val;
                mbusy[z][wr0_num] = 1'b0;
            end
            if (wr1_enable && !(z == 1 && wr1_num == 0)) begin
                mreg[z][wr1_num]  = wr1_val;
                mbusy[z][wr1_num] = 1'b0;
            end
            if (issue_enable && !(z == 1 && issue_num == 0))
                mbusy[z][issue_num] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        wr0_enable = 0; wr1_enable = 0; issue_enable = 0;
    endtask

    task automatic rd3(input int a, input int b, input int c);
        rd_num = {3'(c), 3'(b), 3'(a)};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (rv0 !== 48'h0 || rb0 !== 3'b0 || pc0 !== 4'd0) $display("FAIL reset_init rv=%h rb=%b pc=%0d exp 0", rv0, rb0, pc0); else passed++;
        rst = 1'b0;
        wr0_enable = 1; wr0_num = 3; wr0_val = 16'h1234;
        issue_enable = 1; issue_num = 5;
        tick();
        rd3(3, 5, 0);
        total++; if (rv0[15:0] !== 16'h1234) $display("FAIL reset_prewrite got %h exp 1234", rv0[15:0]); else passed++;
        total++; if (rb0[1] !== 1'b1 || pc0 !== 4'd1) $display("FAIL reset_preissue busy=%b pc=%0d exp 1/1", rb0[1], pc0); else passed++;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            rd3(i, i, i);
            total++; if (rv0 !== 48'h0 || rv1 !== 48'h0) $display("FAIL reset_val[%0d] got %h/%h exp 0", i, rv0, rv1); else passed++;
            total++; if (rb0 !== 3'b0 || rb1 !== 3'b0) $display("FAIL reset_busy[%0d] got %b/%b exp 0", i, rb0, rb1); else passed++;
        end
        total++; if (pc0 !== 4'd0 || pc1 !== 4'd0) $display("FAIL reset_count got %0d/%0d exp 0", pc0, pc1); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dual_write();
        wr0_enable = 1; wr0_num = 2; wr0_val = 16'h00AA;
        wr1_enable = 1; wr1_num = 5; wr1_val = 16'h0055;
        tick();
        rd3(2, 5, 0);
        total++; if (rv0[15:0] !== 16'h00AA || rv1[15:0] !== 16'h00AA) $display("FAIL dual_wr0 got %h/%h exp 00aa", rv0[15:0], rv1[15:0]); else passed++;
        total++; if (rv0[31:16] !== 16'h0055 || rv1[31:16] !== 16'h0055) $display("FAIL dual_wr1 got %h/%h exp 0055", rv0[31:16], rv1[31:16]); else passed++;
        wr0_enable = 1; wr0_num = 4; wr0_val = 16'h1111;
        wr1_enable = 1; wr1_num = 4; wr1_val = 16'h2222;
        tick();
        rd3(4, 4, 4);
        total++; if (rv0[15:0] !== 16'h2222 || rv1[47:32] !== 16'h2222) $display("FAIL collision got %h/%h exp 2222", rv0[15:0], rv1[47:32]); else passed++;
    endtask

    task automatic test_scoreboard();
        issue_enable = 1; issue_num = 6;
        tick();
        rd3(6, 7, 0);
        total++; if (rb0[0] !== 1'b1 || pc0 !== 4'd1) $display("FAIL issue6 busy=%b pc=%0d exp 1/1", rb0[0], pc0); else passed++;
        issue_enable = 1; issue_num = 7;
        tick();
        total++; if (rb0[1:0] !== 2'b11 || pc0 !== 4'd2 || pc1 !== 4'd2) $display("FAIL issue7 busy=%b pc=%0d/%0d exp 11/2", rb0[1:0], pc0, pc1); else passed++;
        wr0_enable = 1; wr0_num = 6; wr0_val = 16'h0BEE;
        tick();
        total++; if (rb0[0] !== 1'b0 || pc0 !== 4'd1) $display("FAIL wb6 busy=%b pc=%0d exp 0/1", rb0[0], pc0); else passed++;
        total++; if (rv0[15:0] !== 16'h0BEE) $display("FAIL wb6_val got %h exp 0bee", rv0[15:0]); else passed++;
        wr1_enable = 1; wr1_num = 6; wr1_val = 16'h0123;
        issue_enable = 1; issue_num = 6;
        tick();
        total++; if (rb0[0] !== 1'b1 || pc0 !== 4'd2 || rv0[15:0] !== 16'h0123) $display("FAIL issue_wr_same busy=%b pc=%0d val=%h exp 1/2/0123", rb0[0], pc0, rv0[15:0]); else passed++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            issue_enable = 1; issue_num = 3'(i);
            tick();
        end
        total++; if (pc0 !== 4'd8) $display("FAIL fill_count got %0d exp 8", pc0); else passed++;
        total++; if (pc1 !== 4'd7) $display("FAIL fill_count_z got %0d exp 7", pc1); else passed++;
        for (int i = 0; i < 8; i++) begin
            wr0_enable = 1; wr0_num = 3'(i); wr0_val = 16'(i * 273);
            tick();
        end
        total++; if (pc0 !== 4'd0 || pc1 !== 4'd0) $display("FAIL drain_count got %0d/%0d exp 0", pc0, pc1); else passed++;
    endtask

    task automatic test_zero_reg();
        wr0_enable = 1; wr0_num = 0; wr0_val = 16'hFFFF;
        issue_enable = 1; issue_num = 0;
        tick();
        rd3(0, 0, 0);
        total++; if (rv1[15:0] !== 16'h0 || rb1[0] !== 1'b0 || pc1 !== 4'd0) $display("FAIL zero_reg val=%h busy=%b pc=%0d exp 0/0/0", rv1[15:0], rb1[0], pc1); else passed++;
        total++; if (rv0[15:0] !== 16'hFFFF || rb0[0] !== 1'b1 || pc0 !== 4'd1) $display("FAIL plain_reg0 val=%h busy=%b pc=%0d exp ffff/1/1", rv0[15:0], rb0[0], pc0); else passed++;
    endtask

    task automatic test_bypass();
        logic [15:0] pre;
`ifdef REG_FILE_BYPASS_EN
        pre = 16'h00C3;
`else
        pre = 16'h0111;
`endif
        rd3(1, 1, 1);
        wr1_enable = 1; wr1_num = 1; wr1_val = 16'h00C3;
        #1;
        total++; if (rv0[15:0] !== pre || rv1[15:0] !== pre) $display("FAIL bypass_pre got %h/%h exp %h", rv0[15:0], rv1[15:0], pre); else passed++;
        total++; if (rb0[0] !== 1'b0) $display("FAIL bypass_busy got %b exp 0", rb0[0]); else passed++;
        tick();
        total++; if (rv0[15:0] !== 16'h00C3) $display("FAIL bypass_post got %h exp 00c3", rv0[15:0]); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                model_reset();
            end
            wr0_enable = 1'($urandom); wr0_num = 3'($urandom); wr0_val = 16'($urandom);
            wr1_enable = 1'($urandom); wr1_num = 3'($urandom); wr1_val = 16'($urandom);
            issue_enable = 1'($urandom); issue_num = 3'($urandom);
            rd3(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            for (int k = 0; k < 3; k++) begin
                total++; if (rv0[k*16 +: 16] !== exp_rd(0, int'(rd_num[k*3 +: 3]))) $display("FAIL rnd_val0 n=%0d k=%0d got %h exp %h", n, k, rv0[k*16 +: 16], exp_rd(0, int'(rd_num[k*3 +: 3]))); else passed++;
                total++; if (rv1[k*16 +: 16] !== exp_rd(1, int'(rd_num[k*3 +: 3]))) $display("FAIL rnd_val1 n=%0d k=%0d got %h exp %h", n, k, rv1[k*16 +: 16], exp_rd(1, int'(rd_num[k*3 +: 3]))); else passed++;
                total++; if (rb0[k] !== exp_busy(0, int'(rd_num[k*3 +: 3])) || rb1[k] !== exp_busy(1, int'(rd_num[k*3 +: 3]))) $display("FAIL rnd_busy n=%0d k=%0d got %b/%b", n, k, rb0[k], rb1[k]); else passed++;
            end
            total++; if (int'(pc0) != mcount(0) || int'(pc1) != mcount(1)) $display("FAIL rnd_count n=%0d got %0d/%0d exp %0d/%0d", n, pc0, pc1, mcount(0), mcount(1)); else passed++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_scoreboard();
        test_fill();
        test_zero_reg();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
